vip_sobel_edge_detector: RTL and testbench
==========================================

// Module: vip_sobel_edge_detector
// PURPOSE
//  Streaming 3x3 Sobel edge detector for the video-processing (VIP) chain.
//  Input is 8-bit luma from the upstream vip_rgb888_ycbcr444 stage; output is one edge bit per pixel.
//  Threshold is user-set; sync/enable strobes pass through with a fixed pipeline delay.
//  One pixel per clk while per_frame_clken=1; no backpressure.
// PARAMETERS
//  IMG_HDISP  640  active pixels per line (line-buffer depth, 2..4096)
//  IMG_VDISP  480  active lines per frame
// PORTS
//  clk               in   1   pixel clock; single clock domain
//  rst_n             in   1   synchronous reset, active-HIGH (codebase port name)
//  per_frame_vsync   in   1   1 = frame active, 0 = vertical blanking
//  per_frame_href    in   1   1 = active line
//  per_frame_clken   in   1   1 = per_img_Y valid this cycle
//  per_img_Y         in   8   input luma
//  Sobel_Threshold   in   8   edge threshold T, sampled every cycle
//  post_frame_vsync  out  1   per_frame_vsync delayed 5 clk
//  post_frame_href   out  1   per_frame_href delayed 5 clk
//  post_frame_clken  out  1   per_frame_clken delayed 5 clk
//  post_img_Bit      out  1   1 = edge pixel
// BEHAVIOUR
//  - Reset (rst_n=1 at posedge): all outputs, pipeline regs, x/y counters -> 0; line-buffer contents don't-care.
//  - Counters: x increments per clken pixel and clears on href falling edge.
//    y increments on each href falling edge and clears while vsync=0.
//  - Two line buffers (depth IMG_HDISP x 8b) hold rows y-1 and y-2, written/shifted on clken only.
//  - Window p[r][c], r,c in 1..3: row1=y-2, row2=y-1, row3=y. Columns x-2,x-1,x; col3 is newest.
//  - Window regs and buffers advance only when clken=1; idle cycles hold state.
//  - Gx = (p13+2*p23+p33) - (p11+2*p21+p31)
//  - Gy = (p11+2*p12+p13) - (p31+2*p32+p33)
//  - Widths: 10-bit partial sums; signed 11-bit differences; |Gx|,|Gy| 10-bit (max 1020).
//  - Squares are 20-bit; sum S is 21-bit. No saturation needed.
//  - Edge decision: post_img_Bit = (S > T*T). Unsigned compare, no sqrt; T=0 => any nonzero gradient.
//  - Border: output for input pixel (x,y) is the edge at (x-1,y-1). Bit forced 0 when x<2 or y<2.
//    This makes output cols 0-1 and rows 0-1 of each frame always 0.
//  - Latency: 5 clk from input clken cycle to its post_frame_clken cycle.
//    Pipeline: window reg, partial sums, abs diff, squares, sum+compare.
//  - vsync/href/clken delayed through a matching 5-stage shift register.
//  - post_img_Bit=0 whenever post_frame_clken=0.
//  - Output pixel count per frame = input count (IMG_HDISP*IMG_VDISP).
//  - Mid-frame reset: outputs 0 next cycle. Processing restarts cleanly at the next vsync rising edge.
//  - Threshold change mid-frame takes effect for pixels entering the compare stage after the change.
// STRUCTURE
//  - Shared vip_pkg: PIX_W=8, GRAD_W=10, SQ_W=21, PIPE_LAT=5 constants.
//  - Natural sub-module: vip_matrix_3x3_8bit. Contains line buffers, x/y counters, the 3x3 window regs,
//    and a window-valid flag (x>=2 && y>=2).
//  - Top holds gradient pipeline, compare, and sync delay line.
// TESTING
//  - Flat frame Y=100, T=128, 16x8 image -> all post_img_Bit=0; exactly 128 clken pulses out.
//  - Vertical step: cols 0-7 Y=0, cols 8-15 Y=255, T=128.
//    |Gx|=1020, S=1040400>16384 -> bit=1 at output cols 8,9 (centres 7,8) for rows>=2, else 0.
//  - Horizontal step: rows 0-3 Y=0, rows 4-7 Y=255 -> bit=1 on output rows 4,5 (centres 3,4) for cols>=2.
//  - Threshold sweep, step 0->50: |Gx|=200, S=40000.
//    T=128 (16384) -> 1; T=200 (40000, not >) -> 0; T=255 -> 0.
//  - Latency/sync: single clken pulse with href/vsync -> post strobes rise exactly 5 clk later.
//    Idle gaps inside href don't change results.
//  - Reset mid-frame at pixel 50 -> all outputs 0 next clk; next full frame matches the flat/step goldens.

Source files
------------

// File: rtl/vip_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vip_pkg
//  Description : Shared widths, types and arithmetic helpers for the Sobel
//                edge detector in the video-processing chain.
//  Revision    : 1.0 - initial release
// ============================================================================
package vip_pkg;

  localparam int PIX_W    = 8;   // luma sample width
  localparam int GRAD_W   = 10;  // partial sums and gradient magnitudes (max 1020)
  localparam int SQ_W     = 21;  // sum of two 20-bit squares
  localparam int PIPE_LAT = 5;   // input clken cycle to post_frame_clken cycle

  typedef logic [PIX_W-1:0]    pix_t;
  typedef logic [GRAD_W-1:0]   grad_t;
  typedef logic [2*GRAD_W-1:0] sq_t;

  // 3x3 window indexed [row][col]; row 0 is the oldest line, col 2 the newest pixel
  typedef logic [2:0][2:0][PIX_W-1:0] win_t;

  typedef struct packed {
    logic vsync;
    logic href;
    logic clken;
  } sync_t;

  // Weighted 1-2-1 column/row sum: a + 2b + c, at most 1020
  function automatic grad_t psum(input pix_t a, input pix_t b, input pix_t c);
    return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
  endfunction

  // Magnitude of a signed 11-bit difference of two partial sums
  function automatic grad_t abs_diff(input grad_t a, input grad_t b);
    logic signed [GRAD_W:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return d[GRAD_W] ? grad_t'(-d) : d[GRAD_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/vip_matrix_3x3_8bit.sv
`default_nettype none
// ============================================================================
//  Module      : vip_matrix_3x3_8bit
//  Description : Two-line-buffer 3x3 window generator with x/y pixel counters
//                and a flag marking windows that lie fully inside the frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module vip_matrix_3x3_8bit
  import vip_pkg::*;
#(
  parameter int IMG_HDISP = 640,
  parameter int IMG_VDISP = 480
) (
  input  logic clk,
  input  logic rst_n,        // synchronous, active-high
  input  logic vsync_i,
  input  logic href_i,
  input  logic clken_i,
  input  pix_t y_i,
  output win_t win_o,
  output logic win_valid_o
);

  localparam int ADDR_W = (IMG_HDISP > 1) ? $clog2(IMG_HDISP) : 1;
  localparam int X_W    = ADDR_W + 1;
  localparam int Y_W    = $clog2(IMG_VDISP) + 1;
  localparam logic [X_W-1:0] c_X_END = X_W'(IMG_HDISP);

  logic [X_W-1:0]    x_q;
  logic [Y_W-1:0]    y_q;
  logic              href_q;
  pix_t              lb1_q [IMG_HDISP];   // row y-1
  pix_t              lb2_q [IMG_HDISP];   // row y-2
  win_t              win_q;
  logic              valid_q;

  logic              w_href_fall;
  logic              w_in_range;
  logic [ADDR_W-1:0] w_addr;
  pix_t              w_row1;
  pix_t              w_row2;

  assign w_href_fall = href_q & ~href_i;
  assign w_in_range  = (x_q < c_X_END);
  assign w_addr      = x_q[ADDR_W-1:0];
  assign w_row1      = w_in_range ? lb2_q[w_addr] : '0;
  assign w_row2      = w_in_range ? lb1_q[w_addr] : '0;

  // Pixel position of the incoming sample: x per pixel, y per line, cleared in vblank
  always_ff @(posedge clk) begin
    if (rst_n) begin
      x_q    <= '0;
      y_q    <= '0;
      href_q <= 1'b0;
    end else begin
      href_q <= href_i;
      if (!vsync_i) begin
        x_q <= '0;
        y_q <= '0;
      end else if (w_href_fall) begin
        x_q <= '0;
        if (y_q != '1) y_q <= y_q + Y_W'(1);
      end else if (clken_i && w_in_range) begin
        x_q <= x_q + X_W'(1);
      end
    end
  end

  // Line buffers shift one row down per pixel; contents need no reset
  always_ff @(posedge clk) begin
    if (clken_i && w_in_range) begin
      lb1_q[w_addr] <= y_i;
      lb2_q[w_addr] <= lb1_q[w_addr];
    end
  end

  // Window shifts left by one column per valid pixel and holds on idle cycles
  always_ff @(posedge clk) begin
    if (rst_n) begin
      win_q   <= '0;
      valid_q <= 1'b0;
    end else if (clken_i) begin
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= win_q[r][1];
        win_q[r][1] <= win_q[r][2];
      end
      win_q[0][2] <= w_row1;
      win_q[1][2] <= w_row2;
      win_q[2][2] <= y_i;
      valid_q     <= (x_q >= X_W'(2)) && (y_q >= Y_W'(2));
    end
  end

  assign win_o       = win_q;
  assign win_valid_o = valid_q;

endmodule
`default_nettype wire

// File: rtl/vip_sobel_edge_detector.sv
`default_nettype none
// ============================================================================
//  Module      : vip_sobel_edge_detector
//  Description : Streaming 3x3 Sobel edge detector; one edge bit per luma
//                pixel, strobes delayed to match the 5-stage pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
module vip_sobel_edge_detector
  import vip_pkg::*;
#(
  parameter int IMG_HDISP = 640,
  parameter int IMG_VDISP = 480
) (
  input  logic             clk,
  input  logic             rst_n,            // synchronous, active-high
  input  logic             per_frame_vsync,
  input  logic             per_frame_href,
  input  logic             per_frame_clken,
  input  logic [PIX_W-1:0] per_img_Y,
  input  logic [PIX_W-1:0] Sobel_Threshold,
  output logic             post_frame_vsync,
  output logic             post_frame_href,
  output logic             post_frame_clken,
  output logic             post_img_Bit
);

  win_t                     win;
  logic                     win_valid;
  sync_t                    w_sync_in;
  sync_t [PIPE_LAT-1:0]     sync_q;
  grad_t                    gxp_q, gxn_q, gyp_q, gyn_q;
  grad_t                    agx_q, agy_q;
  sq_t                      sqx_q, sqy_q;
  logic                     v2_q, v3_q, v4_q;
  logic                     bit_q;
  logic [SQ_W-1:0]          w_sum;
  logic [SQ_W-1:0]          w_thr_sq;
  logic                     w_unused_centre;

  vip_matrix_3x3_8bit #(
    .IMG_HDISP (IMG_HDISP),
    .IMG_VDISP (IMG_VDISP)
  ) u_matrix (
    .clk         (clk),
    .rst_n       (rst_n),
    .vsync_i     (per_frame_vsync),
    .href_i      (per_frame_href),
    .clken_i     (per_frame_clken),
    .y_i         (per_img_Y),
    .win_o       (win),
    .win_valid_o (win_valid)
  );

  // The Sobel kernels have a zero centre weight
  assign w_unused_centre = &{1'b0, win[1][1]};

  assign w_sync_in = '{vsync: per_frame_vsync, href: per_frame_href, clken: per_frame_clken};

  // Strobe delay line matching the gradient pipeline depth
  always_ff @(posedge clk) begin
    if (rst_n) sync_q <= '0;
    else       sync_q <= {sync_q[PIPE_LAT-2:0], w_sync_in};
  end

  // Stage 2: positive and negative 1-2-1 sums for both kernels
  always_ff @(posedge clk) begin
    if (rst_n) begin
      {gxp_q, gxn_q, gyp_q, gyn_q} <= '0;
      v2_q <= 1'b0;
    end else begin
      gxp_q <= psum(win[0][2], win[1][2], win[2][2]);
      gxn_q <= psum(win[0][0], win[1][0], win[2][0]);
      gyp_q <= psum(win[0][0], win[0][1], win[0][2]);
      gyn_q <= psum(win[2][0], win[2][1], win[2][2]);
      v2_q  <= win_valid;
    end
  end

  // Stage 3: gradient magnitudes |Gx|, |Gy|
  always_ff @(posedge clk) begin
    if (rst_n) begin
      {agx_q, agy_q} <= '0;
      v3_q <= 1'b0;
    end else begin
      agx_q <= abs_diff(gxp_q, gxn_q);
      agy_q <= abs_diff(gyp_q, gyn_q);
      v3_q  <= v2_q;
    end
  end

  // Stage 4: squared magnitudes
  always_ff @(posedge clk) begin
    if (rst_n) begin
      {sqx_q, sqy_q} <= '0;
      v4_q <= 1'b0;
    end else begin
      sqx_q <= sq_t'(agx_q) * sq_t'(agx_q);
      sqy_q <= sq_t'(agy_q) * sq_t'(agy_q);
      v4_q  <= v3_q;
    end
  end

  // Squared compare avoids a square root; live threshold applies at this stage
  assign w_sum    = {1'b0, sqx_q} + {1'b0, sqy_q};
  assign w_thr_sq = SQ_W'(Sobel_Threshold) * SQ_W'(Sobel_Threshold);

  // Stage 5: edge decision, forced low off-border and outside clken cycles
  always_ff @(posedge clk) begin
    if (rst_n) bit_q <= 1'b0;
    else       bit_q <= sync_q[PIPE_LAT-2].clken & v4_q & (w_sum > w_thr_sq);
  end

  assign post_frame_vsync = sync_q[PIPE_LAT-1].vsync;
  assign post_frame_href  = sync_q[PIPE_LAT-1].href;
  assign post_frame_clken = sync_q[PIPE_LAT-1].clken;
  assign post_img_Bit     = bit_q;

endmodule
`default_nettype wire

// File: tb/tb_vip_sobel_edge_detector.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_vip_sobel_edge_detector
//  Description : Scoreboard bench for the Sobel edge detector on a 16x8 image.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vip_sobel_edge_detector;

  localparam int W = 16;
  localparam int H = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       vs, hr, ce;
  logic [7:0] yin, thr;
  logic       pvs, phr, pce, pbit;

  always #5 clk = ~clk;

  vip_sobel_edge_detector #(
    .IMG_HDISP (W),
    .IMG_VDISP (H)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .per_frame_vsync  (vs),
    .per_frame_href   (hr),
    .per_frame_clken  (ce),
    .per_img_Y        (yin),
    .Sobel_Threshold  (thr),
    .post_frame_vsync (pvs),
    .post_frame_href  (phr),
    .post_frame_clken (pce),
    .post_img_Bit     (pbit)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit exp_q[$];
  int outs_seen = 0;
  int ones_seen = 0;
  int img[H][W];

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
  endtask

  // Reference: edge at the window centred one pixel up-left of the incoming pixel
  function automatic bit model_edge(input int x, input int y, input int t);
    int cx, cy, gx, gy;
    if (x < 2 || y < 2) return 1'b0;
    cx = x - 1;
    cy = y - 1;
    gx = (img[cy-1][cx+1] + 2*img[cy][cx+1] + img[cy+1][cx+1])
       - (img[cy-1][cx-1] + 2*img[cy][cx-1] + img[cy+1][cx-1]);
    gy = (img[cy-1][cx-1] + 2*img[cy-1][cx] + img[cy-1][cx+1])
       - (img[cy+1][cx-1] + 2*img[cy+1][cx] + img[cy+1][cx+1]);
    return (gx*gx + gy*gy) > (t*t);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pop one expected bit per output pixel; bit must be low otherwise
  always @(negedge clk) begin
    if (pce) begin
      outs_seen++;
      if (pbit) ones_seen++;
      if (exp_q.size() == 0) chk("unexpected_output", 1, 0);
      else chk("edge_bit", int'(pbit), int'(exp_q.pop_front()));
    end else begin
      chk("bit_without_clken", int'(pbit), 0);
    end
  end

  // kind: 0 flat, 1 vertical step 0/255, 2 horizontal step, 3 vertical step 0/50, 4 random
  task automatic run_frame(input int kind, input int t, input bit gaps,
                           input int exp_ones, input int rst_at);
    int pix;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        case (kind)
          0:       img[y][x] = 100;
          1:       img[y][x] = (x < 8) ? 0 : 255;
          2:       img[y][x] = (y < 4) ? 0 : 255;
          3:       img[y][x] = (x < 8) ? 0 : 50;
          default: img[y][x] = int'($urandom_range(0, 255));
        endcase
    outs_seen = 0;
    ones_seen = 0;
    thr = 8'(t);
    vs  = 1'b1;
    repeat (3) cyc();
    pix = 0;
    for (int y = 0; y < H; y++) begin
      hr = 1'b1;
      for (int x = 0; x < W; x++) begin
        if (gaps && $urandom_range(0, 3) == 0) begin
          ce  = 1'b0;
          yin = 8'($urandom);
          cyc();
        end
        if (pix == rst_at) begin
          rst_n = 1'b1;
          ce    = 1'b0;
          cyc();
          exp_q.delete();
          chk("midframe_reset_outputs", int'({pvs, phr, pce, pbit}), 0);
          rst_n = 1'b0;
          vs    = 1'b0;
          hr    = 1'b0;
          repeat (10) cyc();
          return;
        end
        ce  = 1'b1;
        yin = 8'(img[y][x]);
        exp_q.push_back(model_edge(x, y, t));
        cyc();
        pix++;
      end
      ce = 1'b0;
      hr = 1'b0;
      repeat (3) cyc();
    end
    vs = 1'b0;
    repeat (10) cyc();
    chk("output_pixel_count", outs_seen, W*H);
    if (exp_ones >= 0) chk("edge_pixel_count", ones_seen, exp_ones);
    chk("scoreboard_drained", exp_q.size(), 0);
  endtask

  initial begin
    int lat;
    rst_n = 1'b1;
    vs = 1'b0; hr = 1'b0; ce = 1'b0; yin = 8'd0; thr = 8'd128;
    repeat (3) cyc();
    chk("reset_outputs", int'({pvs, phr, pce, pbit}), 0);
    rst_n = 1'b0;
    repeat (2) cyc();

    // Single-pixel pulse: strobes must appear exactly 5 clocks later
    vs = 1'b1; hr = 1'b1; ce = 1'b1; yin = 8'hAA;
    exp_q.push_back(1'b0);
    cyc();
    vs = 1'b0; hr = 1'b0; ce = 1'b0;
    lat = 1;
    while (lat <= 20 && !pce) begin
      cyc();
      lat++;
    end
    chk("latency", lat, 5);
    chk("latency_strobes", int'({pvs, phr, pce}), 7);
    cyc();
    chk("latency_strobes_fall", int'({pvs, phr, pce}), 0);
    repeat (10) cyc();

    run_frame(0, 128, 1'b0, 0,  -1);   // flat
    run_frame(1, 128, 1'b0, 12, -1);   // vertical step
    run_frame(2, 128, 1'b0, 28, -1);   // horizontal step
    run_frame(3, 128, 1'b0, 12, -1);   // |Gx|=200, S=40000 > 16384
    run_frame(3, 200, 1'b0, 0,  -1);   // S == T*T is not an edge
    run_frame(3, 255, 1'b0, 0,  -1);
    run_frame(1, 128, 1'b1, 12, -1);   // idle gaps inside href
    run_frame(0, 0,   1'b1, 0,  -1);   // T=0 on a flat image
    run_frame(4, 128, 1'b0, -1, 50);   // reset mid-frame
    run_frame(0, 128, 1'b0, 0,  -1);
    run_frame(1, 128, 1'b1, 12, -1);
    for (int i = 0; i < 3; i++)
      run_frame(4, int'($urandom_range(0, 255)), 1'b1, -1, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, checks %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
`default_nettype wire
